// File: rtl/sine_monitor_if.sv
// DAC sample bus from the sine generator into sine_monitor, plus its measurement results.
// master drives samples and observes results; slave is the monitor.
interface sine_monitor_if #(
    parameter int WIDTH    = 10,
    parameter int PERIOD_W = 24
);
    // sample_valid qualifies sample_in for one clk; there is no ready, every valid sample is taken.
    logic [WIDTH-1:0]    sample_in;
    logic                sample_valid;
    logic                meas_valid;
    logic [PERIOD_W-1:0] period_out;
    logic [WIDTH-1:0]    min_out;
    logic [WIDTH-1:0]    max_out;
    logic                locked;
    logic                timeout;
    logic                glitch;

    modport master (
        output sample_in, sample_valid,
        input  meas_valid, period_out, min_out, max_out, locked, timeout, glitch
    );

    modport slave (
        input  sample_in, sample_valid,
        output meas_valid, period_out, min_out, max_out, locked, timeout, glitch
    );
endinterface

// File: rtl/sine_monitor.sv
// Measures period and min/max of a DAC sine between rising mid-scale crossings (with hysteresis).
// Optional step-size checker on the sample stream: define SINE_MON_CHECK_EN.
module sine_monitor #(
    parameter int WIDTH    = 10,
    parameter int MID      = 512,
    parameter int HYST     = 8,
    parameter int PERIOD_W = 24,
    parameter int MAX_STEP = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    sine_monitor_if.slave bus,
    output logic [1:0]    state_dbg
);
    if (MID - HYST < 0 || MID + HYST > 2**WIDTH - 1 || MAX_STEP < 1) begin : g_param_check
        $error("sine_monitor: illegal MID/HYST/MAX_STEP");
    end

    typedef enum logic [1:0] {SYNC = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

    localparam logic [WIDTH:0]      LO      = (WIDTH+1)'(MID - HYST);
    localparam logic [WIDTH:0]      HI      = (WIDTH+1)'(MID + HYST);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    state_t              state;
    logic                started;
    logic [PERIOD_W-1:0] counter;
    logic [WIDTH-1:0]    min_trk;
    logic [WIDTH-1:0]    max_trk;
    logic [WIDTH-1:0]    min_next;
    logic [WIDTH-1:0]    max_next;
    logic [WIDTH:0]      sample_ext;
    logic                below_lo;
    logic                above_hi;
    logic                rising;
    logic                saturate;

    assign sample_ext = {1'b0, bus.sample_in};
    assign below_lo   = sample_ext < LO;
    assign above_hi   = sample_ext >= HI;
    assign rising     = bus.sample_valid && (state == LOW) && above_hi;
    assign saturate   = started && (counter == CNT_MAX);
    assign min_next   = (bus.sample_in < min_trk) ? bus.sample_in : min_trk;
    assign max_next   = (bus.sample_in > max_trk) ? bus.sample_in : max_trk;
    assign state_dbg  = state;

    // Counter is zeroed on every rising event, so at the next event counter+1 is the distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SYNC;
            started        <= 1'b0;
            counter        <= '0;
            min_trk        <= '0;
            max_trk        <= '0;
            bus.meas_valid <= 1'b0;
            bus.period_out <= '0;
            bus.min_out    <= '0;
            bus.max_out    <= '0;
            bus.locked     <= 1'b0;
            bus.timeout    <= 1'b0;
        end else begin
            bus.meas_valid <= 1'b0;
            if (counter != CNT_MAX) begin
                counter <= counter + 1'b1;
            end
            if (saturate) begin
                // Lost the waveform: resynchronise, keep the last measurement visible.
                bus.timeout <= 1'b1;
                bus.locked  <= 1'b0;
                started     <= 1'b0;
                state       <= SYNC;
            end else if (bus.sample_valid) begin
                case (state)
                    SYNC:    if (below_lo) state <= LOW;
                    LOW:     if (above_hi) state <= HIGH;
                    HIGH:    if (below_lo) state <= LOW;
                    default: state <= SYNC;
                endcase
                if (rising) begin
                    counter <= '0;
                    started <= 1'b1;
                    min_trk <= bus.sample_in;
                    max_trk <= bus.sample_in;
                    if (started) begin
                        bus.period_out <= counter + 1'b1;
                        bus.min_out    <= min_next;
                        bus.max_out    <= max_next;
                        bus.meas_valid <= 1'b1;
                        bus.locked     <= 1'b1;
                    end
                end else begin
                    min_trk <= min_next;
                    max_trk <= max_next;
                end
            end
        end
    end

`ifdef SINE_MON_CHECK_EN
    localparam logic [WIDTH:0] STEP_LIM = (WIDTH+1)'(MAX_STEP);

    logic [WIDTH-1:0] prev_sample;
    logic             have_prev;
    logic             glitch_q;
    logic [WIDTH-1:0] step_mag;

    assign step_mag = (bus.sample_in >= prev_sample) ? (bus.sample_in - prev_sample)
                                                     : (prev_sample - bus.sample_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample <= '0;
            have_prev   <= 1'b0;
            glitch_q    <= 1'b0;
        end else if (bus.sample_valid) begin
            prev_sample <= bus.sample_in;
            have_prev   <= 1'b1;
            if (have_prev && ({1'b0, step_mag} > STEP_LIM)) begin
                glitch_q <= 1'b1;
            end
        end
    end

    assign bus.glitch = glitch_q;
`else
    assign bus.glitch = 1'b0;
`endif
endmodule

// File: tb/tb_sine_monitor.sv
// Bench for sine_monitor: two instances (PERIOD_W 24 and 8) share one sample stream and are
// compared every cycle against an event-level reference model and a measurement scoreboard.
module tb_sine_monitor;
    localparam int WIDTH    = 10;
    localparam int LO       = 504;
    localparam int HI       = 520;
    localparam int MAX_STEP = 64;
    localparam int PW_A     = 24;
    localparam int PW_B     = 8;
`ifdef SINE_MON_CHECK_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUTs ----------------
    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic [WIDTH-1:0] sample = '0;
    logic             valid  = 1'b0;
    logic [1:0]       dbg_a;
    logic [1:0]       dbg_b;

    always #5 clk = ~clk;

    sine_monitor_if #(.WIDTH(WIDTH), .PERIOD_W(PW_A)) bus_a ();
    sine_monitor_if #(.WIDTH(WIDTH), .PERIOD_W(PW_B)) bus_b ();

    assign bus_a.sample_in    = sample;
    assign bus_a.sample_valid = valid;
    assign bus_b.sample_in    = sample;
    assign bus_b.sample_valid = valid;

    sine_monitor #(.WIDTH(WIDTH), .PERIOD_W(PW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_dbg(dbg_a)
    );
    sine_monitor #(.WIDTH(WIDTH), .PERIOD_W(PW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_dbg(dbg_b)
    );

    // ---------------- reference model ----------------
    // armed: a sample below LO has been seen since sync or the last rising crossing.
    int          limit [2] = '{1 << PW_A, 1 << PW_B};
    bit          armed [2];
    bit          started [2];
    int          ev_cyc [2];
    int          mn [2];
    int          mx [2];
    bit          exp_meas [2];
    bit          exp_locked [2];
    bit          exp_timeout [2];
    int          exp_period [2];
    int          exp_min [2];
    int          exp_max [2];
    bit          exp_glitch;
    bit          have_prev;
    int          prev;
    int          cyc = 0;
    int          model_strobes [2];
    int          seen_strobes [2];
    logic [43:0] exp_q_a [$];
    logic [43:0] exp_q_b [$];
    int          lut [64];
    int          checks   = 0;
    int          failures = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            armed[d]       = 1'b0;
            started[d]     = 1'b0;
            exp_meas[d]    = 1'b0;
            exp_locked[d]  = 1'b0;
            exp_timeout[d] = 1'b0;
            exp_period[d]  = 0;
            exp_min[d]     = 0;
            exp_max[d]     = 0;
        end
        exp_glitch = 1'b0;
        have_prev  = 1'b0;
        prev       = 0;
    endtask

    task automatic model_edge(input bit v, input int s);
        logic [43:0] tup;
        for (int d = 0; d < 2; d++) begin
            exp_meas[d] = 1'b0;
            if (started[d] && (cyc - ev_cyc[d] >= limit[d])) begin
                exp_timeout[d] = 1'b1;
                exp_locked[d]  = 1'b0;
                started[d]     = 1'b0;
                armed[d]       = 1'b0;
            end else if (v) begin
                if (armed[d] && s >= HI) begin
                    armed[d] = 1'b0;
                    if (started[d]) begin
                        exp_period[d] = cyc - ev_cyc[d];
                        exp_min[d]    = (s < mn[d]) ? s : mn[d];
                        exp_max[d]    = (s > mx[d]) ? s : mx[d];
                        exp_meas[d]   = 1'b1;
                        exp_locked[d] = 1'b1;
                        model_strobes[d]++;
                        tup = {24'(exp_period[d]), 10'(exp_min[d]), 10'(exp_max[d])};
                        if (d == 0) exp_q_a.push_back(tup);
                        else        exp_q_b.push_back(tup);
                    end
                    started[d] = 1'b1;
                    ev_cyc[d]  = cyc;
                    mn[d]      = s;
                    mx[d]      = s;
                end else begin
                    if (s < LO) armed[d] = 1'b1;
                    if (s < mn[d]) mn[d] = s;
                    if (s > mx[d]) mx[d] = s;
                end
            end
        end
        if (v) begin
            if (GLITCH_EN && have_prev && ((s > prev ? s - prev : prev - s) > MAX_STEP))
                exp_glitch = 1'b1;
            prev      = s;
            have_prev = 1'b1;
        end
    endtask

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [43:0] tup;
        check("meas_valid_a", 64'(bus_a.meas_valid), 64'(exp_meas[0]));
        check("locked_a",     64'(bus_a.locked),     64'(exp_locked[0]));
        check("timeout_a",    64'(bus_a.timeout),    64'(exp_timeout[0]));
        check("glitch_a",     64'(bus_a.glitch),     64'(exp_glitch));
        check("period_a",     64'(bus_a.period_out), 64'(exp_period[0]));
        check("min_a",        64'(bus_a.min_out),    64'(exp_min[0]));
        check("max_a",        64'(bus_a.max_out),    64'(exp_max[0]));
        check("state_legal_a", 64'(dbg_a != 2'd3),   64'(1));
        check("meas_valid_b", 64'(bus_b.meas_valid), 64'(exp_meas[1]));
        check("locked_b",     64'(bus_b.locked),     64'(exp_locked[1]));
        check("timeout_b",    64'(bus_b.timeout),    64'(exp_timeout[1]));
        check("glitch_b",     64'(bus_b.glitch),     64'(exp_glitch));
        check("period_b",     64'(bus_b.period_out), 64'(exp_period[1]));
        check("min_b",        64'(bus_b.min_out),    64'(exp_min[1]));
        check("max_b",        64'(bus_b.max_out),    64'(exp_max[1]));
        check("state_legal_b", 64'(dbg_b != 2'd3),   64'(1));
        if (bus_a.meas_valid) begin
            seen_strobes[0]++;
            check("sb_a_pending", 64'(exp_q_a.size() > 0), 64'(1));
            if (exp_q_a.size() > 0) begin
                tup = exp_q_a.pop_front();
                check("sb_a_tuple", 64'({bus_a.period_out, bus_a.min_out, bus_a.max_out}), 64'(tup));
            end
        end
        if (bus_b.meas_valid) begin
            seen_strobes[1]++;
            check("sb_b_pending", 64'(exp_q_b.size() > 0), 64'(1));
            if (exp_q_b.size() > 0) begin
                tup = exp_q_b.pop_front();
                check("sb_b_tuple", 64'({16'(bus_b.period_out), bus_b.min_out, bus_b.max_out}), 64'(tup));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, 64'({bus_a.meas_valid, bus_a.period_out, bus_a.min_out, bus_a.max_out,
                                bus_a.locked, bus_a.timeout, bus_a.glitch}), 64'(0));
        check({tag, "_b"}, 64'({bus_b.meas_valid, bus_b.period_out, bus_b.min_out, bus_b.max_out,
                                bus_b.locked, bus_b.timeout, bus_b.glitch}), 64'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input int s);
        valid  = v;
        sample = WIDTH'(s);
        @(posedge clk);
        cyc++;
        model_edge(v, s);
        #1;
        compare_all();
    endtask

    task automatic run_lut(input int n, input int start, input int gap_min, input int gap_max,
                           input int jit);
        for (int k = 0; k < n; k++) begin
            int s;
            s = lut[(start + k) % 64];
            if (jit > 0) s = s + int'($urandom_range(0, 2 * jit)) - jit;
            if (s < 0) s = 0;
            if (s > 1023) s = 1023;
            step(1'b1, s);
            repeat ($urandom_range(gap_min, gap_max)) step(1'b0, int'($urandom_range(0, 1023)));
        end
    endtask

    // Asynchronous reset asserted mid-cycle, held across one rising edge.
    task automatic do_reset();
        #2;
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed / random sequence ----------------
    initial begin
        int hover_base;
        for (int i = 0; i < 64; i++)
            lut[i] = $rtoi(511.5 + 511.5 * $sin(2.0 * 3.141592653589793 * real'(i) / 64.0) + 0.5);
        model_reset();
        model_strobes = '{0, 0};
        seen_strobes  = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Full-scale sine, valid every clk.
        run_lut(320, 0, 0, 0, 0);
        check("t1_period", 64'(bus_a.period_out), 64'(64));
        check("t1_min",    64'(bus_a.min_out),    64'(0));
        check("t1_max",    64'(bus_a.max_out),    64'(1023));
        check("t1_locked", 64'(bus_a.locked),     64'(1));

        // Valid every 4th clk: period quadruples, the 8-bit instance saturates.
        run_lut(320, 0, 3, 3, 0);
        check("t2_period", 64'(bus_a.period_out), 64'(256));
        check("t2_min",    64'(bus_a.min_out),    64'(0));
        check("t2_max",    64'(bus_a.max_out),    64'(1023));

        // Noise inside the hysteresis band.
        hover_base = seen_strobes[0];
        for (int k = 0; k < 200; k++) step(1'b1, int'($urandom_range(505, 519)));
        check("t3_no_strobe", 64'(seen_strobes[0] - hover_base), 64'(0));

        // Lock, stall on a constant, then re-lock.
        do_reset();
        run_lut(192, 0, 0, 0, 0);
        check("t4_locked_b", 64'(bus_b.locked), 64'(1));
        for (int k = 0; k < 300; k++) step(1'b1, 100);
        check("t4_timeout_b",  64'(bus_b.timeout), 64'(1));
        check("t4_unlocked_b", 64'(bus_b.locked),  64'(0));
        check("t4_locked_a",   64'(bus_a.locked),  64'(1));
        run_lut(192, 0, 0, 0, 0);
        check("t4_relock_b",   64'(bus_b.locked),  64'(1));
        check("t4_sticky_b",   64'(bus_b.timeout), 64'(1));

        // Reset mid-period while locked.
        run_lut(96, 0, 0, 0, 0);
        do_reset();
        run_lut(70, 0, 0, 0, 0);
        check("t5_not_locked", 64'(bus_a.locked), 64'(0));
        run_lut(64, 6, 0, 0, 0);
        check("t5_relocked", 64'(bus_a.locked), 64'(1));

        // Step-size violation.
        do_reset();
        step(1'b1, 900);
        step(1'b1, 400);
        step(1'b1, 600);
        check("t6_glitch", 64'(bus_a.glitch), 64'(GLITCH_EN));
        step(1'b0, 0);
        step(1'b1, 610);
        check("t6_glitch_sticky", 64'(bus_a.glitch), 64'(GLITCH_EN));

        // Randomised phase, gaps and amplitude jitter.
        do_reset();
        run_lut(384, int'($urandom_range(0, 63)), 0, 3, 3);
        run_lut(128, int'($urandom_range(0, 63)), 0, 1, 2);

        check("sb_a_drained", 64'(exp_q_a.size()), 64'(0));
        check("sb_b_drained", 64'(exp_q_b.size()), 64'(0));
        check("strobes_a", 64'(seen_strobes[0]), 64'(model_strobes[0]));
        check("strobes_b", 64'(seen_strobes[1]), 64'(model_strobes[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
